seven_seg_capture: RTL and testbench
====================================

Name: seven_seg_capture

Overview:
- Receive-side counterpart of the letter/digit seven-segment driver.
- Samples the multiplexed display bus (abcdefgh plus one-hot digit strobe), rebuilds the character shown on every digit position and keeps a per-position text image.
- Emits a change event through a valid/ready stream.
- Used as a display sniffer feeding UART or debug logic, and as a self-checking monitor in lab benches.

Parameters:
- w_digit, 8, number of digit positions and width of the digit strobe.
- stable_cycles, 4, consecutive identical samples required before a dwell is accepted (range 1..255).
- fifo_depth, 4, event FIFO entries (power of 2, at least 2).
- timeout_cycles, 1000000, refresh timeout; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- abcdefgh  input  8  segment bus; bit 7 = a … bit 1 = g, bit 0 = h (decimal point); 1 = lit.
- digit  input  w_digit  digit strobe; active-high; bit i selects position i.
- clr_ovf  input  1  one-cycle pulse that clears the overflow flag.
- ev_valid  output  1  event available.
- ev_ready  input  1  consumer accepts the event.
- ev_index  output  $clog2(w_digit)  position whose character changed.
- ev_char  output  8  ASCII code of the new character.
- ev_dp  output  1  decimal-point state of the new character.
- text  output  8*w_digit  current ASCII image; position i occupies bits [8i+7:8i].
- overflow  output  1  sticky flag: an event was dropped.

Behaviour:
- Input sampling: abcdefgh and digit are registered once. All decisions below use the registered values.
- A sample is valid only when digit is exactly one-hot. Zero-hot and multi-hot samples are invalid.
- Sampler state machine:
  - IDLE: entered on any invalid sample. On a valid sample, store pattern/index, set count=1, go to SETTLE.
  - SETTLE: a sample differing in pattern or index restarts SETTLE with count=1; an invalid sample returns to IDLE. When count reaches stable_cycles, perform an accept and go to LOCKED.
  - LOCKED: stays while samples are identical. An invalid sample goes to IDLE. A different valid sample goes to SETTLE with count=1.
- Accept:
  - Decode the pattern (bits 7:1) to ASCII:
    - Digits 0-9.
    - Letters A, b, C, d, E, F, G (1011_110), H, L, P, U.
    - Blank (all off) decodes to 0x20.
    - Any other pattern decodes to '?' (0x3F).
  - The dp bit (bit 0) is kept separately per position.
  - If {char, dp} differs from the stored slot: update the slot the next cycle and push {index, char, dp} into the FIFO.
  - An identical value produces no event.
- Latency: from the first registered sample of a stable dwell, the slot/text update and FIFO push occur stable_cycles+1 cycles later. ev_valid rises the cycle after the push when the FIFO was empty.
- FIFO:
  - ev_* reflect the head entry.
  - Pop when ev_valid && ev_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - A push while full with no pop drops the new event and sets overflow. text is still updated.
- overflow:
  - Cleared by clr_ovf.
  - A set in the same cycle as clr_ovf wins.
- Reset (rst=0, asynchronous):
  - State IDLE; count 0; FIFO empty; ev_valid=0; ev_index=0; ev_char=0; ev_dp=0; overflow=0.
  - All text slots = 0x20 and all dp = 0.
  - The first accepted non-blank character after reset therefore always generates an event.
- A reset asserted mid-dwell discards the partial count. Entries queued but not yet accepted are lost.

Optional Feature:
- Macro: SEVEN_SEG_CAPTURE_TIMEOUT_EN.
- With the macro defined:
  - Each position has a counter that is reloaded on every valid sample addressing that position.
  - When a counter reaches timeout_cycles, that slot is forced to 0x20/dp=0. If the slot was not already blank, an event {i, 0x20, 0} is pushed.
  - When several positions expire in the same cycle, the lowest index is served first and the others follow on successive cycles.
- Without the macro: no timeout logic; slots hold their last value indefinitely.

Test Plan:
- Drive abcdefgh=8'b1000_1110, digit=8'b0000_1000 for 10 cycles → one event {index=3, char=0x46 'F', dp=0}; text[31:24]=0x46.
- Scan F, P (1100_1110), G (1011_1100), A (1110_1110) on digits 3,2,1,0 with 8 cycles each, repeated 5 times → exactly 4 events; text[31:0]=0x46504741.
- Drive pattern 1111_1111 on digit 0 for stable_cycles-1 cycles, then switch digit → no event. Then drive 1111_1111 on digit 0 for stable_cycles cycles → event {0, 0x38 '8', dp=1}.
- Drive digit=8'b0000_0011 or 8'b0 with any pattern for 20 cycles → no event; text unchanged.
- With ev_ready=0, produce 6 distinct changes → 4 events queued, overflow=1. Pulse clr_ovf → overflow=0. Then raise ev_ready → the 4 events drain in order.
- With SEVEN_SEG_CAPTURE_TIMEOUT_EN and timeout_cycles=50: show 'E' (1001_1110) on digit 2, then stop strobing → event {2, 0x45}, then 50 cycles later event {2, 0x20}.

Source files
------------

// File: rtl/seven_seg_capture_if.sv
// Change-event stream between seven_seg_capture (master) and its consumer (slave).
interface seven_seg_capture_if #(
    parameter int w_index = 3
);
    logic               ev_valid;
    logic               ev_ready;
    logic [w_index-1:0] ev_index;
    logic [7:0]         ev_char;
    logic               ev_dp;

    modport master (output ev_valid, ev_index, ev_char, ev_dp, input ev_ready);
    modport slave  (input ev_valid, ev_index, ev_char, ev_dp, output ev_ready);
endinterface

// File: rtl/seven_seg_capture.sv
// Sniffs a multiplexed seven-segment bus, rebuilds the per-digit ASCII image and streams change events.
// Define SEVEN_SEG_CAPTURE_TIMEOUT_EN to blank digits whose strobe stops refreshing.
module seven_seg_capture #(
    parameter int w_digit        = 8,
    parameter int stable_cycles  = 4,
    parameter int fifo_depth     = 4,
    parameter int timeout_cycles = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           abcdefgh,
    input  logic [w_digit-1:0]   digit,
    input  logic                 clr_ovf,
    seven_seg_capture_if.master  ev,
    output logic [8*w_digit-1:0] text,
    output logic                 overflow
);
    localparam int w_index = $clog2(w_digit);
    localparam int w_ptr   = $clog2(fifo_depth);
    localparam int w_fill  = w_ptr + 1;
    localparam int w_entry = w_index + 9;

    localparam logic [7:0]      stable_target = 8'(stable_cycles);
    localparam logic [7:0]      ascii_blank   = 8'h20;
    localparam logic [w_fill-1:0] fifo_full_lvl = w_fill'(fifo_depth);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    function automatic logic [7:0] decode_glyph(input logic [6:0] seg);
        case (seg)
            7'b1111110: decode_glyph = 8'h30;
            7'b0110000: decode_glyph = 8'h31;
            7'b1101101: decode_glyph = 8'h32;
            7'b1111001: decode_glyph = 8'h33;
            7'b0110011: decode_glyph = 8'h34;
            7'b1011011: decode_glyph = 8'h35;
            7'b1011111: decode_glyph = 8'h36;
            7'b1110000: decode_glyph = 8'h37;
            7'b1111111: decode_glyph = 8'h38;
            7'b1111011: decode_glyph = 8'h39;
            7'b1110111: decode_glyph = 8'h41; // A
            7'b0011111: decode_glyph = 8'h62; // b
            7'b1001110: decode_glyph = 8'h43; // C
            7'b0111101: decode_glyph = 8'h64; // d
            7'b1001111: decode_glyph = 8'h45; // E
            7'b1000111: decode_glyph = 8'h46; // F
            7'b1011110: decode_glyph = 8'h47; // G
            7'b0110111: decode_glyph = 8'h48; // H
            7'b0001110: decode_glyph = 8'h4C; // L
            7'b1100111: decode_glyph = 8'h50; // P
            7'b0111110: decode_glyph = 8'h55; // U
            7'b0000000: decode_glyph = ascii_blank;
            default:    decode_glyph = 8'h3F;
        endcase
    endfunction

    logic [7:0]         seg_q;
    logic [w_digit-1:0] dig_q;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q <= '0;
            dig_q <= '0;
        end else begin
            seg_q <= abcdefgh;
            dig_q <= digit;
        end
    end

    logic               sample_valid;
    logic [w_index-1:0] sample_idx;

    assign sample_valid = (dig_q != '0) && ((dig_q & (dig_q - w_digit'(1))) == '0);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sample_idx = '0;
        for (int i = 0; i < w_digit; i++) begin
            if (dig_q[i]) sample_idx = w_index'(i);
        end
    end

    logic [1:0]         state_q, state_d;
    logic [7:0]         pat_q, pat_d;
    logic [w_index-1:0] idx_q, idx_d;
    logic [7:0]         count_q, count_d;
    logic               sample_same;
    logic               accept;

    assign sample_same = (seg_q == pat_q) && (sample_idx == idx_q);

    // The accept fires once the stored dwell has been seen stable_cycles times,
    // independent of what the current sample does next.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        count_d = count_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (sample_valid) begin
                    state_d = ST_SETTLE;
                    pat_d   = seg_q;
                    idx_d   = sample_idx;
                    count_d = 8'd1;
                end
            end
            ST_SETTLE: begin
                accept = (count_q == stable_target);
                if (!sample_valid) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (!sample_same) begin
                    pat_d   = seg_q;
                    idx_d   = sample_idx;
                    count_d = 8'd1;
                end else if (accept) begin
                    state_d = ST_LOCKED;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            ST_LOCKED: begin
                if (!sample_valid) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (!sample_same) begin
                    state_d = ST_SETTLE;
                    pat_d   = seg_q;
                    idx_d   = sample_idx;
                    count_d = 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    logic [7:0]         char_q [w_digit];
    logic [w_digit-1:0] dp_q;
    logic [7:0]         acc_char;
    logic               acc_change;

    assign acc_char   = decode_glyph(pat_q[7:1]);
    assign acc_change = accept && ((acc_char != char_q[idx_q]) || (pat_q[0] != dp_q[idx_q]));

    logic               push_req;
    logic [w_index-1:0] push_idx;
    logic [7:0]         push_char;
    logic               push_dp;

`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
    localparam int               w_tmo     = $clog2(timeout_cycles + 1);
    localparam logic [w_tmo-1:0] tmo_limit = w_tmo'(timeout_cycles);

    logic [w_tmo-1:0]   tmo_q [w_digit];
    logic               tmo_hit;
    logic [w_index-1:0] tmo_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < w_digit; i++) tmo_q[i] <= '0;
        end else begin
            for (int i = 0; i < w_digit; i++) begin
                if (sample_valid && (sample_idx == w_index'(i))) begin
                    tmo_q[i] <= '0;
                end else if (tmo_q[i] != tmo_limit) begin
                    tmo_q[i] <= tmo_q[i] + w_tmo'(1);
                end
            end
        end
    end

    // Expired slots that are already blank need no service; lowest index wins.
    always_comb begin
        tmo_hit = 1'b0;
        tmo_idx = '0;
        for (int i = w_digit - 1; i >= 0; i--) begin
            if ((tmo_q[i] == tmo_limit) && ((char_q[i] != ascii_blank) || dp_q[i])) begin
                tmo_hit = 1'b1;
                tmo_idx = w_index'(i);
            end
        end
    end

    // A sampler accept owns the single push slot; a pending timeout waits a cycle.
    always_comb begin
        push_req  = acc_change || tmo_hit;
        push_idx  = idx_q;
        push_char = acc_char;
        push_dp   = pat_q[0];
        if (!acc_change) begin
            push_idx  = tmo_idx;
            push_char = ascii_blank;
            push_dp   = 1'b0;
        end
    end
`else
    assign push_req  = acc_change;
    assign push_idx  = idx_q;
    assign push_char = acc_char;
    assign push_dp   = pat_q[0];

    logic unused_timeout;
    assign unused_timeout = (timeout_cycles > 0);
`endif

    // The text image follows every change, even when the event itself is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < w_digit; i++) char_q[i] <= ascii_blank;
            dp_q <= '0;
        end else if (push_req) begin
            char_q[push_idx] <= push_char;
            dp_q[push_idx]   <= push_dp;
        end
    end

    for (genvar g = 0; g < w_digit; g++) begin : g_text
        assign text[8*g +: 8] = char_q[g];
    end

    logic [w_entry-1:0] fifo_mem_q [fifo_depth];
    logic [w_ptr-1:0]   rd_ptr_q, wr_ptr_q;
    logic [w_fill-1:0]  fill_q;
    logic               ev_valid_int;
    logic               fifo_full;
    logic               pop;
    logic               do_push;
    logic               drop;
    logic [w_entry-1:0] head;

    assign ev_valid_int = (fill_q != '0);
    assign fifo_full    = (fill_q == fifo_full_lvl);
    assign pop          = ev_valid_int && ev.ev_ready;
    assign do_push      = push_req && (!fifo_full || pop);
    assign drop         = push_req && fifo_full && !pop;

    // NOTE: the FIFO storage is not reset; entries are only read once written, and outputs are gated by valid.
    always_ff @(posedge clk) begin
        if (do_push) fifo_mem_q[wr_ptr_q] <= {push_idx, push_char, push_dp};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + w_ptr'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + w_ptr'(1);
            case ({do_push, pop})
                2'b10:   fill_q <= fill_q + w_fill'(1);
                2'b01:   fill_q <= fill_q - w_fill'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    assign head        = fifo_mem_q[rd_ptr_q];
    assign ev.ev_valid = ev_valid_int;
    assign ev.ev_index = ev_valid_int ? head[w_entry-1 -: w_index] : '0;
    assign ev.ev_char  = ev_valid_int ? head[8:1] : '0;
    assign ev.ev_dp    = ev_valid_int ? head[0] : 1'b0;

    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overflow_q <= 1'b0;
        else      overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: run-length behavioural model plus directed literal checks.
module tb_seven_seg_capture;
    localparam int SC    = 4;
    localparam int DEPTH = 4;

    localparam logic [7:0] NUM_PAT [6] = '{8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE};

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] ch;
        logic       dp;
    } ev_t;

    typedef struct {
        int         due;
        logic [7:0] pat;
        logic [2:0] idx;
    } acc_t;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [7:0]  seg_in  = '0;
    logic [7:0]  dig_in  = '0;
    logic        clr_ovf = 1'b0;
    logic [63:0] text;
    logic        overflow;
    logic        cmp_en  = 1'b0;

    seven_seg_capture_if #(.w_index(3)) ev_if ();

    seven_seg_capture #(
        .w_digit        (8),
        .stable_cycles  (SC),
        .fifo_depth     (DEPTH),
        .timeout_cycles (1000000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .abcdefgh (seg_in),
        .digit    (dig_in),
        .clr_ovf  (clr_ovf),
        .ev       (ev_if),
        .text     (text),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    function automatic logic [7:0] to_ascii(input logic [6:0] seg);
        logic [6:0] pats [22];
        string      glyphs;
        pats = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
                 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111, 7'b1011110, 7'b0110111,
                 7'b0001110, 7'b1100111, 7'b0111110, 7'b0000000};
        glyphs = "0123456789AbCdEFGHLPU ";
        to_ascii = 8'h3F;
        for (int k = 0; k < 22; k++) begin
            if (pats[k] == seg) to_ascii = glyphs[k];
        end
    endfunction

    // Model: a run of SC identical one-hot captures becomes visible two edges after the SC-th capture.
    logic [63:0] m_text;
    logic [7:0]  m_dp;
    logic        m_ovf;
    ev_t         mq [$];
    acc_t        pend [$];
    int          run_len;
    logic [15:0] run_key;
    int          edge_no;
    acc_t        acc;
    logic [7:0]  m_ch;
    bit          m_pop;
    bit          m_drop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_text  = {8{8'h20}};
            m_dp    = '0;
            m_ovf   = 1'b0;
            mq.delete();
            pend.delete();
            run_len = 0;
            run_key = '0;
            edge_no = 0;
        end else begin
            edge_no++;
            m_pop  = (mq.size() != 0) && ev_if.ev_ready;
            m_drop = 1'b0;
            if (m_pop) void'(mq.pop_front());
            if (pend.size() != 0 && pend[0].due == edge_no) begin
                acc  = pend.pop_front();
                m_ch = to_ascii(acc.pat[7:1]);
                if (m_text[int'(acc.idx)*8 +: 8] != m_ch || m_dp[acc.idx] != acc.pat[0]) begin
                    m_text[int'(acc.idx)*8 +: 8] = m_ch;
                    m_dp[acc.idx] = acc.pat[0];
                    if (mq.size() < DEPTH) mq.push_back(ev_t'{acc.idx, m_ch, acc.pat[0]});
                    else m_drop = 1'b1;
                end
            end
            if (m_drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if ($countones(dig_in) == 1) begin
                if (run_len != 0 && {seg_in, dig_in} == run_key) run_len++;
                else begin
                    run_len = 1;
                    run_key = {seg_in, dig_in};
                end
                if (run_len == SC) pend.push_back('{due: edge_no + 2, pat: seg_in, idx: 3'($clog2(dig_in))});
            end else begin
                run_len = 0;
            end
        end
    end

    ev_t got [$];

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ev_valid", 64'(ev_if.ev_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) check("ev_head", 64'({ev_if.ev_index, ev_if.ev_char, ev_if.ev_dp}), 64'(mq[0]));
            check("text", text, m_text);
            check("overflow", 64'(overflow), 64'(m_ovf));
            if (ev_if.ev_valid && ev_if.ev_ready) got.push_back(ev_t'{ev_if.ev_index, ev_if.ev_char, ev_if.ev_dp});
        end
    end

    task automatic show(input logic [7:0] seg, input logic [7:0] dig, input int n);
        seg_in = seg;
        dig_in = dig;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        seg_in = '0;
        dig_in = '0;
        clr_ovf = 1'b0;
        ev_if.ev_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ev_valid", 64'(ev_if.ev_valid), 64'd0);
        check("rst_ev_fields", 64'({ev_if.ev_index, ev_if.ev_char, ev_if.ev_dp}), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_text", text, 64'h2020202020202020);
        @(posedge clk);
        #1;
        rst = 1'b1;
        got.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ev_if.ev_ready = 1'b1;
        #3;
        do_reset();
        cmp_en = 1'b1;

        // Single stable 'F' on digit 3.
        show(8'h8E, 8'h08, 10);
        show(8'h00, 8'h00, 6);
        check("t1_count", 64'(got.size()), 64'd1);
        check("t1_event", 64'(got[0]), 64'({3'd3, 8'h46, 1'b0}));
        check("t1_text", 64'(text[31:24]), 64'h46);

        // Scanned F P G A on digits 3..0, five passes.
        do_reset();
        repeat (5) begin
            show(8'h8E, 8'h08, 8);
            show(8'hCE, 8'h04, 8);
            show(8'hBC, 8'h02, 8);
            show(8'hEE, 8'h01, 8);
        end
        show(8'h00, 8'h00, 6);
        check("t2_count", 64'(got.size()), 64'd4);
        check("t2_ev0", 64'(got[0]), 64'({3'd3, 8'h46, 1'b0}));
        check("t2_ev1", 64'(got[1]), 64'({3'd2, 8'h50, 1'b0}));
        check("t2_ev2", 64'(got[2]), 64'({3'd1, 8'h47, 1'b0}));
        check("t2_ev3", 64'(got[3]), 64'({3'd0, 8'h41, 1'b0}));
        check("t2_text", 64'(text[31:0]), 64'h46504741);

        // Dwell one sample short, then a full dwell of '8' with dp.
        do_reset();
        show(8'hFF, 8'h01, SC - 1);
        show(8'hFF, 8'h02, 2);
        show(8'h00, 8'h00, 6);
        check("t3_short_count", 64'(got.size()), 64'd0);
        show(8'hFF, 8'h01, SC);
        show(8'h00, 8'h00, 6);
        check("t3_count", 64'(got.size()), 64'd1);
        check("t3_event", 64'(got[0]), 64'({3'd0, 8'h38, 1'b1}));

        // Multi-hot and zero-hot strobes are ignored.
        got.delete();
        show(8'h8E, 8'h03, 20);
        show(8'hEE, 8'h00, 20);
        check("t4_count", 64'(got.size()), 64'd0);
        check("t4_text", text, 64'h2020202020202038);

        // Six changes with the consumer stalled: four queued, overflow set.
        do_reset();
        ev_if.ev_ready = 1'b0;
        for (int i = 0; i < 6; i++) show(NUM_PAT[i], 8'(1 << i), 6);
        show(8'h00, 8'h00, 6);
        check("t5_overflow", 64'(overflow), 64'd1);
        check("t5_valid", 64'(ev_if.ev_valid), 64'd1);
        check("t5_text", text, 64'h2020363534333231);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        check("t5_ovf_cleared", 64'(overflow), 64'd0);
        ev_if.ev_ready = 1'b1;
        show(8'h00, 8'h00, 8);
        check("t5_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("t5_drain", 64'(got[i]), 64'({3'(i), 8'(8'h31 + i), 1'b0}));

        // Push landing on the same edge as a pop from a full FIFO.
        do_reset();
        ev_if.ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) show(NUM_PAT[i], 8'(1 << i), 6);
        show(NUM_PAT[4], 8'h10, 5);
        ev_if.ev_ready = 1'b1;
        show(NUM_PAT[4], 8'h10, 1);
        show(8'h00, 8'h00, 8);
        check("t6_overflow", 64'(overflow), 64'd0);
        check("t6_count", 64'(got.size()), 64'd5);
        check("t6_last", 64'(got[4]), 64'({3'd4, 8'h35, 1'b0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
